// File: rtl/huff_pkg.sv
// Shared constants and types for the Huffman encoder sequencing controller.
package huff_pkg;

  localparam int MAX_CHARS = 5;
  localparam int CHAR_W    = 7;
  localparam int CODE_W    = 15;
  localparam int IDX_W     = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int CNT_W     = $clog2(MAX_CHARS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } seq_state_t;

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [MAX_CHARS-1:0][CHAR_W-1:0] frame_t;
  typedef logic [MAX_CHARS-1:0][CODE_W-1:0] code_arr_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/huff_cap_buf.sv
// Capture buffer for the per-slot encoded value/mask arrays with a registered
// read port addressed by slot index.
module huff_cap_buf
  import huff_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [MAX_CHARS-1:0][CODE_W-1:0] value_in,
  input  logic [MAX_CHARS-1:0][CODE_W-1:0] mask_in,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [CODE_W-1:0]                rd_value,
  output logic [CODE_W-1:0]                rd_mask
);

  code_arr_t value_q;
  code_arr_t mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      mask_q  <= '0;
    end else if (load) begin
      value_q <= value_in;
      mask_q  <= mask_in;
    end
  end

  // Bypass on load so slot 0 is already presented on the first drain cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_value <= '0;
      rd_mask  <= '0;
    end else if (load) begin
      rd_value <= value_in[rd_idx];
      rd_mask  <= mask_in[rd_idx];
    end else begin
      rd_value <= value_q[rd_idx];
      rd_mask  <= mask_q[rd_idx];
    end
  end

endmodule

// File: rtl/huff_enc_seq.sv
// Sequencer around the combinational Huffman datapath: fill, settle, capture, drain.
// Optional statistics counters (frame_cnt, stall_cnt) are enabled by HUFF_SEQ_STATS_EN.
module huff_enc_seq
  import huff_pkg::*;
#(
  parameter int SETTLE_CYC = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHAR_W-1:0]                in_char,
  input  logic                             in_last,
  output logic [MAX_CHARS-1:0][CHAR_W-1:0] enc_data,
  output logic                             enc_en,
  input  logic [MAX_CHARS-1:0][CODE_W-1:0] enc_value,
  input  logic [MAX_CHARS-1:0][CODE_W-1:0] enc_mask,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDX_W-1:0]                 out_idx,
  output logic [CODE_W-1:0]                out_value,
  output logic [CODE_W-1:0]                out_mask,
  output logic                             out_last,
`ifdef HUFF_SEQ_STATS_EN
  output logic [15:0]                      frame_cnt,
  output logic [15:0]                      stall_cnt,
`endif
  output logic                             busy
);

  localparam logic [CNT_W-1:0] LAST_SLOT   = CNT_W'(MAX_CHARS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

  seq_state_t       state;
  seq_state_t       next_state;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] frame_len;
  logic [3:0]       settle_cnt;
  logic [IDX_W-1:0] out_idx_nxt;
  logic             in_ready_nxt;
  logic             enc_en_nxt;
  logic             out_valid_nxt;
  logic             out_last_nxt;
  logic             busy_nxt;
  logic             in_hs;
  logic             out_hs;
  logic             frame_done;
  frame_t           first_frame;

  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  // fill_cnt is 0 in IDLE, so a one-slot frame completes on its first symbol.
  assign frame_done = in_hs && (in_last || (fill_cnt == LAST_SLOT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_hs) begin
          next_state = frame_done ? SETTLE : FILL;
        end else begin
          next_state = IDLE;
        end
      end
      FILL: begin
        if (frame_done) begin
          next_state = SETTLE;
        end else begin
          next_state = FILL;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          next_state = CAPTURE;
        end else begin
          next_state = SETTLE;
        end
      end
      CAPTURE: next_state = DRAIN;
      DRAIN: begin
        if (out_hs && out_last) begin
          next_state = IDLE;
        end else begin
          next_state = DRAIN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered copies track the state register.
  always_comb begin
    in_ready_nxt  = (next_state == IDLE) || (next_state == FILL);
    enc_en_nxt    = (next_state == SETTLE) || (next_state == CAPTURE);
    out_valid_nxt = (next_state == DRAIN);
    busy_nxt      = (next_state != IDLE);
    out_idx_nxt   = out_idx;
    if (state == CAPTURE) begin
      out_idx_nxt = '0;
    end else if (out_hs) begin
      out_idx_nxt = out_last ? '0 : (out_idx + IDX_ONE);
    end else begin
      out_idx_nxt = out_idx;
    end
    out_last_nxt = out_valid_nxt && (CNT_W'(out_idx_nxt) == (frame_len - CNT_ONE));
  end

  always_comb begin
    first_frame    = '0;
    first_frame[0] = in_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      enc_en    <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      enc_en    <= enc_en_nxt;
      out_valid <= out_valid_nxt;
      out_idx   <= out_idx_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
    end
  end

  // A new frame clears every slot so short frames leave zeros behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_data   <= '0;
      fill_cnt   <= '0;
      frame_len  <= '0;
      settle_cnt <= '0;
    end else begin
      if (in_hs) begin
        fill_cnt <= fill_cnt + CNT_ONE;
        if (frame_done) begin
          frame_len <= fill_cnt + CNT_ONE;
        end
        if (state == IDLE) begin
          enc_data <= first_frame;
        end else begin
          enc_data[fill_cnt[IDX_W-1:0]] <= in_char;
        end
      end
      if (state == SETTLE) begin
        settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : (settle_cnt + 4'd1);
      end else begin
        settle_cnt <= 4'd0;
      end
      if ((state == DRAIN) && out_hs && out_last) begin
        fill_cnt <= '0;
      end
    end
  end

  huff_cap_buf u_cap_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (state == CAPTURE),
    .value_in (enc_value),
    .mask_in  (enc_mask),
    .rd_idx   (out_idx_nxt),
    .rd_value (out_value),
    .rd_mask  (out_mask)
  );

`ifdef HUFF_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'h0000;
      stall_cnt <= 16'h0000;
    end else begin
      if (out_hs && out_last) begin
        frame_cnt <= sat_inc16(frame_cnt);
      end
      if ((state == DRAIN) && out_valid && !out_ready) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
    end
  end
`endif

endmodule

// File: doc/huff_enc_seq.md
Name: huff_enc_seq

Overview:
- Sequencing controller for the combinational Huffman encoder datapath.
- Collects a character stream (valid/ready) into a frame of up to MAX_CHARS symbols and presents the frame to the datapath with data_en asserted.
- Holds the frame stable for a fixed settle window, then captures the per-slot encoded value/mask arrays and drains them one slot per accepted beat.
- Sits between the upstream byte source and the downstream bit packer.

Parameters:
- MAX_CHARS, 5, frame depth in symbols; must equal the datapath's max character length.
- CHAR_W, 7, symbol width (7-bit ASCII).
- CODE_W, 15, encoded value/mask width (2*6+3).
- SETTLE_CYC, 4, cycles data_en is held before capture; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input symbol valid
- in_ready  out  1  controller accepts symbol
- in_char  in  CHAR_W  input symbol
- in_last  in  1  last symbol of frame (short frame)
- enc_data  out  MAX_CHARS x CHAR_W  frame to datapath
- enc_en  out  1  datapath enable (data_en)
- enc_value  in  MAX_CHARS x CODE_W  datapath encoded values
- enc_mask  in  MAX_CHARS x CODE_W  datapath encoded masks
- out_valid  out  1  encoded slot valid
- out_ready  in  1  downstream accepts slot
- out_idx  out  $clog2(MAX_CHARS)  slot index
- out_value  out  CODE_W  captured value for out_idx
- out_mask  out  CODE_W  captured mask for out_idx
- out_last  out  1  final slot of frame
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; in_ready=0; enc_en=0; enc_data all 0; out_valid=0; out_idx=0; out_value=0; out_mask=0; out_last=0; fill_cnt=0; settle_cnt=0.
- FSM states: IDLE, FILL, SETTLE, CAPTURE, DRAIN.
- IDLE: in_ready=1. A handshake (in_valid&in_ready) writes enc_data[0] and sets fill_cnt=1. If in_last or MAX_CHARS==1, go to SETTLE; otherwise go to FILL.
- FILL: in_ready=1. Each handshake writes enc_data[fill_cnt] and increments fill_cnt. Go to SETTLE on handshake with in_last, or when fill_cnt reaches MAX_CHARS-1 before increment (frame full). in_valid=0 stalls with no change.
- Short frame: unwritten slots hold 7'h00; frame_len=fill_cnt is latched on SETTLE entry.
- SETTLE: in_ready=0; enc_en=1; enc_data frozen; settle_cnt counts 0..SETTLE_CYC-1, then go to CAPTURE.
- CAPTURE (1 cycle): enc_en=1; enc_value/enc_mask arrays registered into an internal capture buffer; go to DRAIN.
- Datapath-to-capture latency is SETTLE_CYC+1 cycles from the frame-complete handshake.
- enc_en deasserts on DRAIN entry.
- DRAIN: out_valid=1; out_idx starts at 0; out_value/out_mask = capture[out_idx]. On out_valid&out_ready, out_idx increments.
- DRAIN: out_last=1 when out_idx==frame_len-1. A handshake with out_last clears out_valid, out_idx=0, fill_cnt=0, state=IDLE.
- out_ready=0 holds all out_* stable (AXI-style: no retraction, no change while valid&!ready).
- Exactly frame_len beats are emitted; slots >= frame_len are never emitted.
- in_ready=0 in SETTLE/CAPTURE/DRAIN. No overlap of frames; back-to-back frames have a 1-cycle IDLE gap minimum.
- rst asserted in any state aborts the frame; all outputs return to reset values next edge; the partial frame is discarded.
- in_last with in_valid=0 is ignored.

Optional Feature:
- Macro HUFF_SEQ_STATS_EN.
- Defined: adds outputs frame_cnt (16b, increments on each out_last handshake, saturates at 16'hFFFF) and stall_cnt (16b, increments each DRAIN cycle with out_valid&!out_ready, saturates). Both are cleared by rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package huff_pkg:
  - constants MAX_CHARS, CHAR_W, CODE_W.
  - typedef enum logic [2:0] seq_state_t {IDLE, FILL, SETTLE, CAPTURE, DRAIN}.
  - typedefs char_t (logic [CHAR_W-1:0]) and code_t (logic [CODE_W-1:0]).
- One natural sub-module, huff_cap_buf: capture register array with load strobe and read index, producing out_value/out_mask.
- FSM and counters stay in huff_enc_seq.

Test Plan:
- Reset then stream "ae aa" (5 beats, in_last on beat 5, out_ready=1): enc_en high exactly 5 cycles (SETTLE_CYC=4 + CAPTURE); 5 out beats idx 0..4; out_last on idx 4; outputs equal enc_value/enc_mask sampled at CAPTURE.
- Short frame "ab" with in_last on beat 2: enc_data = {'a','b',0,0,0}; exactly 2 out beats; out_last on idx 1.
- Backpressure: out_ready toggled 1,0,0,1 during DRAIN: out_idx/out_value stable while stalled; stall_cnt=2 with HUFF_SEQ_STATS_EN.
- in_valid gaps in FILL (valid pattern 1,0,1,0,1,1,1): fill_cnt advances only on handshakes; SETTLE entered after the 5th accepted symbol; in_ready=0 thereafter until IDLE.
- rst pulsed mid-SETTLE, then a new frame "zzzzz": all outputs at reset values the cycle after rst; new frame drains 5 beats with no residue from the aborted frame.
- Two back-to-back full frames: frame_cnt=2; second frame in_ready rises the cycle after the first out_last handshake.
